// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage: IF stage of the 5-stage RV32I pipeline.
// Holds the PC register and the IF/ID pipeline register. It drives the word
// address to a combinational-read instruction memory and captures the word
// that comes back. Hazard stalls and EX-stage redirects (flush) are applied
// here, before the decode stage sees the instruction.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   When it is defined, a redirect to a non-word-aligned target turns the next
//   IF/ID load into a bubble and raises fetch_misalign_o for that slot.
//   When it is undefined, the low target bits are dropped and fetch_misalign_o
//   is tied to 0.
//
// Ports
//   clk              in   1   clock, rising edge
//   reset            in   1   asynchronous, active-low reset
//   stall_i          in   1   hold PC and IF/ID (load-use hazard)
//   flush_i          in   1   redirect taken in EX; squash the current fetch
//   redirect_pc_i    in   32  redirect target, sampled when flush_i=1
//   pc_o             out  32  current PC (byte address, always word aligned)
//   instr_i          in   32  instruction word for pc_o (same cycle)
//   if_id_pc_o       out  32  PC of the instruction in IF/ID
//   if_id_pc4_o      out  32  if_id_pc_o + 4 (link value)
//   if_id_instr_o    out  32  instruction in IF/ID
//   if_id_valid_o    out  1   1 = real instruction, 0 = bubble
//   fetch_misalign_o out  1   misaligned redirect flag for the IF/ID slot
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 64,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        fetch_misalign_o
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_if_id_pc;
    logic [XLEN-1:0] r_if_id_pc4;
    logic [XLEN-1:0] r_if_id_instr;
    logic            r_if_id_valid;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_in_range;
    logic            w_fetch_ok;

    // Sequential PC increment wraps naturally modulo 2^32.
    assign w_pc_plus4    = r_pc + XLEN'(4);
    assign w_redirect_pc = redirect_pc_i & ~XLEN'(3);
    // Word index compared against the memory depth; beyond it the fetch is junk.
    assign w_in_range    = XLEN'({2'b00, r_pc[XLEN-1:2]}) < XLEN'(IMEM_WORDS);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misalign_pend;
    logic r_misalign;

    // A pending misaligned redirect poisons the first advance after the flush.
    assign w_fetch_ok = w_in_range && !r_misalign_pend;

    // Misalign tracking: armed by flush, consumed by the next advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misalign_pend <= 1'b0;
            r_misalign      <= 1'b0;
        end else if (flush_i) begin
            r_misalign_pend <= (redirect_pc_i[1:0] != 2'b00);
            r_misalign      <= 1'b0;
        end else if (!stall_i) begin
            r_misalign_pend <= 1'b0;
            r_misalign      <= r_misalign_pend;
        end
    end

    assign fetch_misalign_o = r_misalign;
`else
    assign w_fetch_ok       = w_in_range;
    assign fetch_misalign_o = 1'b0;
`endif

    // PC and IF/ID register: flush beats stall beats advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_if_id_pc    <= '0;
            r_if_id_pc4   <= '0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (flush_i) begin
            // Squash the word fetched this cycle; IF/ID pc/pc4 keep their values.
            r_pc          <= w_redirect_pc;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (!stall_i) begin
            r_pc          <= w_pc_plus4;
            r_if_id_pc    <= r_pc;
            r_if_id_pc4   <= w_pc_plus4;
            r_if_id_instr <= w_fetch_ok ? instr_i : NOP_INSTR;
            r_if_id_valid <= w_fetch_ok;
        end
    end

    assign pc_o          = r_pc;
    assign if_id_pc_o    = r_if_id_pc;
    assign if_id_pc4_o   = r_if_id_pc4;
    assign if_id_instr_o = r_if_id_instr;
    assign if_id_valid_o = r_if_id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage: self-checking bench for fetch_stage.
// Directed vector table, hand-written corner sequences (memory boundary,
// PC wrap, asynchronous reset, misaligned redirect) and a randomized run
// compared against a reference model of the fetch rules.
// Honours FETCH_MISALIGN_TRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 64;
    localparam logic [31:0] JUNK  = 32'hBADC_0FFE;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic        fetch_misalign_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .redirect_pc_i    (redirect_pc_i),
        .pc_o             (pc_o),
        .instr_i          (instr_i),
        .if_id_pc_o       (if_id_pc_o),
        .if_id_pc4_o      (if_id_pc4_o),
        .if_id_instr_o    (if_id_instr_o),
        .if_id_valid_o    (if_id_valid_o),
        .fetch_misalign_o (fetch_misalign_o)
    );

    // Instruction memory: mem[i] = 0x1000_0000 + i; junk beyond its depth.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        int unsigned idx;
        idx = addr / 4;
        if (idx < DEPTH) return 32'h1000_0000 + addr / 4;
        return JUNK;
    endfunction

    assign instr_i = mem_word(pc_o);

    // Reference model state (what the outputs should be).
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_valid, m_mis, m_pend;

    function automatic bit trap_en();
`ifdef FETCH_MISALIGN_TRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP;
        m_valid = 1'b0; m_mis = 1'b0; m_pend = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic f, input logic [31:0] t);
        if (f) begin
            m_pc    = (t / 4) * 4;
            m_instr = NOP;
            m_valid = 1'b0;
            m_mis   = 1'b0;
            m_pend  = trap_en() && (t % 4 != 0);
        end else if (!s) begin
            m_ipc  = m_pc;
            m_ipc4 = m_pc + 32'd4;
            if (m_pend) begin
                m_instr = NOP; m_valid = 1'b0; m_mis = 1'b1;
            end else if (m_pc / 4 < DEPTH) begin
                m_instr = 32'h1000_0000 + m_pc / 4; m_valid = 1'b1; m_mis = 1'b0;
            end else begin
                m_instr = NOP; m_valid = 1'b0; m_mis = 1'b0;
            end
            m_pend = 1'b0;
            m_pc   = m_pc + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"},    pc_o,          m_pc);
        chk({tag, ".ipc"},   if_id_pc_o,    m_ipc);
        chk({tag, ".ipc4"},  if_id_pc4_o,   m_ipc4);
        chk({tag, ".instr"}, if_id_instr_o, m_instr);
        chk({tag, ".valid"}, 32'(if_id_valid_o),    32'(m_valid));
        chk({tag, ".mis"},   32'(fetch_misalign_o), 32'(m_mis));
    endtask

    // Apply one cycle of control inputs, let the edge happen, sample #1 later.
    task automatic cycle(input logic s, input logic f, input logic [31:0] t);
        stall_i = s; flush_i = f; redirect_pc_i = t;
        model_step(s, f, t);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_pc_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk_model("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_ipc;
        logic [31:0] e_instr;
        logic        e_valid;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Directed table, starting right after reset (pc_o = 0).
        vecs[0]  = '{0, 0, 32'h0,  32'h04, 32'h00, 32'h1000_0000, 1};
        vecs[1]  = '{0, 0, 32'h0,  32'h08, 32'h04, 32'h1000_0001, 1};
        vecs[2]  = '{1, 0, 32'h0,  32'h08, 32'h04, 32'h1000_0001, 1};
        vecs[3]  = '{1, 0, 32'h0,  32'h08, 32'h04, 32'h1000_0001, 1};
        vecs[4]  = '{0, 0, 32'h0,  32'h0C, 32'h08, 32'h1000_0002, 1};
        vecs[5]  = '{0, 1, 32'h20, 32'h20, 32'h08, NOP,           0};
        vecs[6]  = '{0, 0, 32'h0,  32'h24, 32'h20, 32'h1000_0008, 1};
        vecs[7]  = '{1, 1, 32'h4,  32'h04, 32'h20, NOP,           0};
        vecs[8]  = '{0, 0, 32'h0,  32'h08, 32'h04, 32'h1000_0001, 1};
        vecs[9]  = '{0, 1, 32'h40, 32'h40, 32'h04, NOP,           0};
        vecs[10] = '{0, 1, 32'h80, 32'h80, 32'h04, NOP,           0};
        vecs[11] = '{0, 0, 32'h0,  32'h84, 32'h80, 32'h1000_0020, 1};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].stall, vecs[i].flush, vecs[i].tgt);
            chk($sformatf("vec%0d.pc", i),    pc_o,          vecs[i].e_pc);
            chk($sformatf("vec%0d.ipc", i),   if_id_pc_o,    vecs[i].e_ipc);
            chk($sformatf("vec%0d.ipc4", i),  if_id_pc4_o,   vecs[i].e_ipc + 32'd4);
            chk($sformatf("vec%0d.instr", i), if_id_instr_o, vecs[i].e_instr);
            chk($sformatf("vec%0d.valid", i), 32'(if_id_valid_o), 32'(vecs[i].e_valid));
        end

        // Memory boundary: 0xFC is the last valid word, 0x100 is out of range.
        cycle(0, 1, 32'hF8);
        cycle(0, 0, 32'h0);
        chk("bnd_fc.pc", pc_o, 32'hFC);
        cycle(0, 0, 32'h0);
        chk("bnd_fc.ipc", if_id_pc_o, 32'hFC);
        chk("bnd_fc.instr", if_id_instr_o, 32'h1000_003F);
        chk("bnd_fc.valid", 32'(if_id_valid_o), 32'd1);
        cycle(0, 0, 32'h0);
        chk("bnd_100.ipc", if_id_pc_o, 32'h100);
        chk("bnd_100.instr", if_id_instr_o, NOP);
        chk("bnd_100.valid", 32'(if_id_valid_o), 32'd0);
        chk("bnd_100.noX", 32'($isunknown({pc_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o,
                                            if_id_valid_o, fetch_misalign_o})), 32'd0);

        // PC wrap from 0xFFFF_FFFC to 0.
        cycle(0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 32'h0);
        chk("wrap.pc", pc_o, 32'h0);
        chk("wrap.ipc", if_id_pc_o, 32'hFFFF_FFFC);
        chk("wrap.ipc4", if_id_pc4_o, 32'h0);
        chk("wrap.valid", 32'(if_id_valid_o), 32'd0);
        chk_model("wrap");

        // Asynchronous reset mid-cycle while pc_o = 0x18, with stall and flush high.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(0, 0, 32'h0);
        chk("pre_async.pc", pc_o, 32'h18);
        stall_i = 1'b1; flush_i = 1'b1; redirect_pc_i = 32'h40;
        #3;
        reset = 1'b0;
        #1;
        chk("async.pc", pc_o, 32'h0);
        chk("async.ipc", if_id_pc_o, 32'h0);
        chk("async.ipc4", if_id_pc4_o, 32'h0);
        chk("async.instr", if_id_instr_o, NOP);
        chk("async.valid", 32'(if_id_valid_o), 32'd0);
        chk("async.mis", 32'(fetch_misalign_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Misaligned redirect to 0x22: pc_o aligns to 0x20.
        cycle(0, 1, 32'h22);
        chk("mis.pc", pc_o, 32'h20);
        cycle(0, 0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis.valid", 32'(if_id_valid_o), 32'd0);
        chk("mis.flag", 32'(fetch_misalign_o), 32'd1);
        chk("mis.instr", if_id_instr_o, NOP);
        cycle(1, 0, 32'h0);
        chk("mis_hold.flag", 32'(fetch_misalign_o), 32'd1);
        cycle(0, 0, 32'h0);
        chk("mis_clr.flag", 32'(fetch_misalign_o), 32'd0);
        chk("mis_clr.instr", if_id_instr_o, 32'h1000_0009);
`else
        chk("mis.valid", 32'(if_id_valid_o), 32'd1);
        chk("mis.flag", 32'(fetch_misalign_o), 32'd0);
        chk("mis.instr", if_id_instr_o, 32'h1000_0008);
`endif
        chk_model("mis_end");

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic s, f;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 300));
            cycle(s, f, t);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
